// File: rtl/bidir_line_arbiter.sv
// ============================================================================
// bidir_line_arbiter
//
// Shares one bidirectional data line between a local write requester (this
// side drives the line) and a far-end read requester (the far side drives the
// line). Grants whole bursts, owns the tristate output enable, inserts idle
// turnaround cycles whenever the line direction flips, and strobes one
// drive/sample window per beat.
//
// Ports
//   clk      in   1      rising-edge clock
//   reset    in   1      asynchronous active-low reset
//   wr_req   in   1      write burst request (level, held until wr_gnt)
//   wr_len   in   LEN_W  write beats, 0 is treated as 1
//   rd_req   in   1      read burst request (level, held until rd_gnt)
//   rd_len   in   LEN_W  read beats, 0 is treated as 1
//   wr_gnt   out  1      pulse on the first write beat cycle
//   rd_gnt   out  1      pulse on the first read beat cycle
//   oe       out  1      1 = local side drives the line
//   wr_beat  out  1      write beat driven this cycle
//   rd_beat  out  1      read beat to be sampled this cycle
//   dir      out  1      last/current direction, 1 = write, 0 = read
//   ta_busy  out  1      turnaround (idle line) cycle
//
// Optional feature macro: BIDIR_ARB_STARVE_EN
//   When defined, a streak counter limits how many consecutive bursts the
//   current direction may take while the other side is waiting; at
//   STARVE_LIMIT the next arbitration is forced to the other direction.
//   When undefined the arbiter is purely same-direction-first.
// ============================================================================
module bidir_line_arbiter #(
    parameter int LEN_W        = 8,
    parameter int TA_WR2RD     = 2,
    parameter int TA_RD2WR     = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_req,
    input  logic [LEN_W-1:0] wr_len,
    input  logic             rd_req,
    input  logic [LEN_W-1:0] rd_len,
    output logic             wr_gnt,
    output logic             rd_gnt,
    output logic             oe,
    output logic             wr_beat,
    output logic             rd_beat,
    output logic             dir,
    output logic             ta_busy
);

    localparam int TA_MAX = (TA_WR2RD > TA_RD2WR) ? TA_WR2RD : TA_RD2WR;
    localparam int TA_W   = (TA_MAX < 2) ? 1 : $clog2(TA_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TA    = 2'd1,
        ST_DRIVE = 2'd2,
        ST_RECV  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [TA_W-1:0]  ta_cnt_q, ta_cnt_d;
    logic             dir_q, dir_d;
    logic             wr_gnt_q, wr_gnt_d;
    logic             rd_gnt_q, rd_gnt_d;
    logic             oe_q, oe_d;
    logic             wr_beat_q, wr_beat_d;
    logic             rd_beat_q, rd_beat_d;
    logic             ta_busy_q, ta_busy_d;

    logic             same_req_s;
    logic             other_req_s;
    logic             force_s;
    logic             pick_s;
    logic             arb_s;
    logic             load_s;
    logic [TA_W-1:0]  ta_len_s;

    // A zero-length request still occupies the line for one beat.
    function automatic logic [LEN_W-1:0] beats_of(input logic [LEN_W-1:0] len);
        if (len == {LEN_W{1'b0}}) begin
            beats_of = LEN_W'(1);
        end else begin
            beats_of = len;
        end
    endfunction

    // Requests seen relative to the direction the line currently faces.
    assign same_req_s  = dir_q ? wr_req : rd_req;
    assign other_req_s = dir_q ? rd_req : wr_req;

`ifdef BIDIR_ARB_STARVE_EN
    localparam int SW = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);

    logic [SW-1:0] streak_q, streak_d;
    logic          new_other_s;

    // Once the streak is exhausted and the other side waits, it must win.
    assign force_s     = (streak_q >= SW'(STARVE_LIMIT)) && other_req_s;
    assign new_other_s = dir_d ? rd_req : wr_req;

    // Streak of bursts granted in one direction while the other side waits.
    always_comb begin
        streak_d = streak_q;
        if (load_s) begin
            if (dir_d != dir_q) begin
                streak_d = new_other_s ? SW'(1) : {SW{1'b0}};
            end else if (other_req_s) begin
                streak_d = (streak_q >= SW'(STARVE_LIMIT)) ? streak_q : streak_q + SW'(1);
            end else begin
                streak_d = {SW{1'b0}};
            end
        end else if (dir_d != dir_q) begin
            streak_d = {SW{1'b0}};
        end else if (!other_req_s) begin
            streak_d = {SW{1'b0}};
        end else begin
            streak_d = streak_q;
        end
    end

    // Streak register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            streak_q <= {SW{1'b0}};
        end else begin
            streak_q <= streak_d;
        end
    end
`else
    assign force_s = 1'b0;
`endif

    // Direction choice at an arbitration point and the turnaround it costs.
    always_comb begin
        if (force_s) begin
            pick_s = ~dir_q;
        end else if (same_req_s) begin
            pick_s = dir_q;
        end else begin
            pick_s = ~dir_q;
        end
        // Choosing write means the line turns read->write, and vice versa.
        ta_len_s = pick_s ? TA_W'(TA_RD2WR) : TA_W'(TA_WR2RD);
    end

    // Next-state logic: arbitration, turnaround countdown, beat countdown.
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        ta_cnt_d   = ta_cnt_q;
        dir_d      = dir_q;
        arb_s      = 1'b0;
        load_s     = 1'b0;
        wr_gnt_d   = 1'b0;
        rd_gnt_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                arb_s = 1'b1;
            end
            ST_TA: begin
                if (ta_cnt_q <= TA_W'(1)) begin
                    // dir already faces the new side; grant only if it still asks.
                    if (same_req_s) begin
                        load_s = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    ta_cnt_d = ta_cnt_q - TA_W'(1);
                end
            end
            ST_DRIVE, ST_RECV: begin
                // The last beat doubles as the next arbitration point so that
                // same-direction bursts chain without a bubble.
                if (beat_cnt_q <= LEN_W'(1)) begin
                    arb_s = 1'b1;
                end else begin
                    beat_cnt_d = beat_cnt_q - LEN_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (arb_s) begin
            if (wr_req || rd_req) begin
                dir_d = pick_s;
                if ((pick_s != dir_q) && (ta_len_s != {TA_W{1'b0}})) begin
                    state_d  = ST_TA;
                    ta_cnt_d = ta_len_s;
                end else begin
                    load_s = 1'b1;
                end
            end else begin
                state_d = ST_IDLE;
            end
        end else begin
            dir_d = dir_q;
        end

        if (load_s) begin
            state_d    = dir_d ? ST_DRIVE : ST_RECV;
            beat_cnt_d = beats_of(dir_d ? wr_len : rd_len);
            ta_cnt_d   = {TA_W{1'b0}};
            wr_gnt_d   = dir_d;
            rd_gnt_d   = ~dir_d;
        end else if (state_d == ST_IDLE) begin
            beat_cnt_d = {LEN_W{1'b0}};
            ta_cnt_d   = {TA_W{1'b0}};
        end else begin
            wr_gnt_d = 1'b0;
            rd_gnt_d = 1'b0;
        end
    end

    // Line-side strobes follow the state being entered so they can be registered.
    always_comb begin
        oe_d      = (state_d == ST_DRIVE);
        wr_beat_d = (state_d == ST_DRIVE);
        rd_beat_d = (state_d == ST_RECV);
        ta_busy_d = (state_d == ST_TA);
    end

    // State, counters and registered outputs; reset releases the line at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            beat_cnt_q <= {LEN_W{1'b0}};
            ta_cnt_q   <= {TA_W{1'b0}};
            dir_q      <= 1'b0;
            wr_gnt_q   <= 1'b0;
            rd_gnt_q   <= 1'b0;
            oe_q       <= 1'b0;
            wr_beat_q  <= 1'b0;
            rd_beat_q  <= 1'b0;
            ta_busy_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            ta_cnt_q   <= ta_cnt_d;
            dir_q      <= dir_d;
            wr_gnt_q   <= wr_gnt_d;
            rd_gnt_q   <= rd_gnt_d;
            oe_q       <= oe_d;
            wr_beat_q  <= wr_beat_d;
            rd_beat_q  <= rd_beat_d;
            ta_busy_q  <= ta_busy_d;
        end
    end

    assign wr_gnt  = wr_gnt_q;
    assign rd_gnt  = rd_gnt_q;
    assign oe      = oe_q;
    assign wr_beat = wr_beat_q;
    assign rd_beat = rd_beat_q;
    assign dir     = dir_q;
    assign ta_busy = ta_busy_q;

endmodule

// File: tb/tb_bidir_line_arbiter.sv
// ============================================================================
// tb_bidir_line_arbiter
//
// Directed scenarios followed by random request traffic. A transaction-level
// reference model schedules the expected per-cycle line activity (turnaround
// slots, then one slot per beat) into a queue whenever the line becomes free,
// and every cycle the DUT outputs are compared against the head of the queue.
// ============================================================================
module tb_bidir_line_arbiter;

    localparam int LEN_W        = 8;
    localparam int TA_WR2RD     = 2;
    localparam int TA_RD2WR     = 1;
    localparam int STARVE_LIMIT = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             wr_req = 1'b0;
    logic             rd_req = 1'b0;
    logic [LEN_W-1:0] wr_len = 8'd0;
    logic [LEN_W-1:0] rd_len = 8'd0;
    logic             wr_gnt, rd_gnt, oe, wr_beat, rd_beat, dir, ta_busy;

    always #5 clk = ~clk;

    bidir_line_arbiter #(
        .LEN_W(LEN_W), .TA_WR2RD(TA_WR2RD), .TA_RD2WR(TA_RD2WR), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk), .reset(reset),
        .wr_req(wr_req), .wr_len(wr_len), .rd_req(rd_req), .rd_len(rd_len),
        .wr_gnt(wr_gnt), .rd_gnt(rd_gnt), .oe(oe), .wr_beat(wr_beat),
        .rd_beat(rd_beat), .dir(dir), .ta_busy(ta_busy)
    );

    // One expected line slot.
    typedef struct packed {
        logic wg; logic rg; logic oe; logic wb; logic rb; logic ta; logic d;
    } slot_t;

    slot_t exp_q[$];
    bit    mdir;       // direction the model believes the line faces
    bit    pend;       // a turnaround is running; decide at its end
    int    streak;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    bit wr_hold = 0, rd_hold = 0, rnd_mode = 0, drop_in_ta = 0;
    int n_wr_gnt = 0, n_rd_gnt = 0;
    int n_wg_obs, n_rg_obs, n_ta_obs, n_oe_obs, n_wb_obs, n_rb_obs;
    int last_wg_cyc = 0, wg_gap = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    task automatic clr_obs();
        n_wg_obs = 0; n_rg_obs = 0; n_ta_obs = 0;
        n_oe_obs = 0; n_wb_obs = 0; n_rb_obs = 0;
    endtask

    task automatic model_reset();
        exp_q.delete();
        mdir = 1'b0; pend = 1'b0; streak = 0;
    endtask

    // Schedule a whole burst in the current model direction.
    task automatic push_burst();
        int n;
        slot_t b;
        n = mdir ? int'(wr_len) : int'(rd_len);
        if (n == 0) n = 1;
        for (int i = 0; i < n; i++) begin
            b = '0;
            b.wg = mdir && (i == 0);
            b.rg = !mdir && (i == 0);
            b.oe = mdir; b.wb = mdir; b.rb = !mdir; b.d = mdir;
            exp_q.push_back(b);
        end
        if (mdir ? rd_req : wr_req) streak = (streak + 1 > STARVE_LIMIT) ? STARVE_LIMIT : streak + 1;
        else streak = 0;
    endtask

    // Called with the inputs the DUT sees at the coming edge.
    task automatic model_decide();
        bit w, r, pick;
        int ta;
        slot_t t;
        w = wr_req; r = rd_req;
        if (!(mdir ? r : w)) streak = 0;
        if (exp_q.size() != 0) return;
        if (pend) begin
            pend = 1'b0;
            if (mdir ? w : r) push_burst();
            return;
        end
        if (!w && !r) return;
        pick = (mdir ? w : r) ? mdir : !mdir;
`ifdef BIDIR_ARB_STARVE_EN
        if (streak >= STARVE_LIMIT && (mdir ? r : w)) pick = !mdir;
`endif
        if (pick != mdir) begin
            mdir = pick;
            streak = 0;
            ta = mdir ? TA_RD2WR : TA_WR2RD;
            if (ta > 0) begin
                t = '0; t.ta = 1'b1; t.d = mdir;
                repeat (ta) exp_q.push_back(t);
                pend = 1'b1;
                return;
            end
        end
        push_burst();
    endtask

    function automatic logic [LEN_W-1:0] rand_len();
        case ($urandom_range(0, 9))
            0: rand_len = 8'd0;
            1: rand_len = 8'd16;
            default: rand_len = LEN_W'($urandom_range(1, 4));
        endcase
    endfunction

    task automatic random_stim();
        if (!wr_req) begin
            if ($urandom_range(0, 3) == 0) begin wr_req = 1'b1; wr_len = rand_len(); end
        end else if ($urandom_range(0, 19) == 0) begin
            wr_req = 1'b0;
        end
        if (!rd_req) begin
            if ($urandom_range(0, 3) == 0) begin rd_req = 1'b1; rd_len = rand_len(); end
        end else if ($urandom_range(0, 19) == 0) begin
            rd_req = 1'b0;
        end
    endtask

    // One clock: model decision, edge, compare, requester reaction.
    task automatic tick();
        slot_t e, o;
        if (reset) model_decide();
        @(posedge clk);
        #1;
        cyc++;
        if (exp_q.size() != 0) e = exp_q.pop_front();
        else begin e = '0; e.d = mdir; end
        o = {wr_gnt, rd_gnt, oe, wr_beat, rd_beat, ta_busy, dir};
        check_eq("outputs", o, e);
        check_eq("oe_in_ta_or_recv", {31'd0, oe & (ta_busy | rd_beat)}, 32'd0);
        if (o.wg) begin n_wg_obs++; wg_gap = cyc - last_wg_cyc; last_wg_cyc = cyc; end
        if (o.rg) n_rg_obs++;
        if (o.ta) n_ta_obs++;
        if (o.oe) n_oe_obs++;
        if (o.wb) n_wb_obs++;
        if (o.rb) n_rb_obs++;
        if (e.wg) begin n_wr_gnt++; if (!wr_hold) wr_req = 1'b0; end
        if (e.rg) begin n_rd_gnt++; if (!rd_hold) rd_req = 1'b0; end
        if (drop_in_ta && e.ta) begin wr_req = 1'b0; rd_req = 1'b0; end
        if (rnd_mode) random_stim();
    endtask

    task automatic drain(input string tag, input int budget);
        int c;
        bit busy;
        c = 0;
        do begin
            tick();
            c++;
            busy = (exp_q.size() != 0) || pend || wr_req || rd_req;
        end while (busy && c < budget);
        check_eq(tag, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, bw, br;
        model_reset();
        clr_obs();
        #1 reset = 1'b0;
        #1;
        check_eq("reset_state", {25'd0, wr_gnt, rd_gnt, oe, wr_beat, rd_beat, ta_busy, dir}, 32'd0);
        tick();
        tick();
        reset = 1'b1;

        // 1: write from reset (dir=0) -> one turnaround, then 4 beats
        clr_obs();
        wr_len = 8'd4; wr_req = 1'b1;
        drain("t1_timeout", 20);
        check_eq("t1_ta_cycles", n_ta_obs, 1);
        check_eq("t1_wr_beats", n_wb_obs, 4);
        check_eq("t1_oe_cycles", n_oe_obs, 4);
        check_eq("t1_wr_gnts", n_wg_obs, 1);
        tick();
        check_eq("t1_dir_after", {31'd0, dir}, 32'd1);

        // 2: read after write -> two turnaround cycles, 3 beats, oe low
        clr_obs();
        rd_len = 8'd3; rd_req = 1'b1;
        drain("t2_timeout", 20);
        check_eq("t2_ta_cycles", n_ta_obs, 2);
        check_eq("t2_rd_beats", n_rb_obs, 3);
        check_eq("t2_rd_gnts", n_rg_obs, 1);
        check_eq("t2_oe_cycles", n_oe_obs, 0);

        // 3: two back-to-back 2-beat writes
        clr_obs();
        wr_len = 8'd2; wr_hold = 1'b1; wr_req = 1'b1;
        bw = n_wr_gnt; c = 0;
        while (n_wr_gnt == bw && c < 10) begin tick(); c++; end
        wr_hold = 1'b0;
        drain("t3_timeout", 20);
        check_eq("t3_wr_gnts", n_wg_obs, 2);
        check_eq("t3_wr_beats", n_wb_obs, 4);
        check_eq("t3_gnt_gap", wg_gap, 2);

        // 5: both sides request continuously with dir=1
        clr_obs();
        wr_len = 8'd2; rd_len = 8'd2;
        wr_hold = 1'b1; rd_hold = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
        bw = n_wr_gnt; br = n_rd_gnt; c = 0;
        while ((n_wr_gnt - bw) < 50 && n_rd_gnt == br && c < 600) begin tick(); c++; end
`ifdef BIDIR_ARB_STARVE_EN
        check_eq("t5_wr_before_rd", n_wg_obs, STARVE_LIMIT);
        check_eq("t5_rd_granted", n_rg_obs, 1);
`else
        check_eq("t5_wr_bursts", n_wg_obs, 50);
        check_eq("t5_rd_starved", n_rg_obs, 0);
`endif
        wr_hold = 1'b0; rd_hold = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
        drain("t5_timeout", 40);

        // maximum-length burst, no counter wrap
        clr_obs();
        wr_len = 8'hFF; wr_req = 1'b1;
        drain("tmax_timeout", 300);
        check_eq("tmax_wr_beats", n_wb_obs, 255);

        // 4: zero length is one beat; reset in the middle of an 8-beat burst
        clr_obs();
        wr_len = 8'd0; wr_req = 1'b1;
        drain("t4_timeout", 20);
        check_eq("t4_len0_beats", n_wb_obs, 1);
        clr_obs();
        wr_len = 8'd8; wr_req = 1'b1;
        c = 0;
        while (n_wb_obs < 3 && c < 20) begin tick(); c++; end
        check_eq("t4_mid_burst", {31'd0, oe}, 32'd1);
        reset = 1'b0;
        #1;
        check_eq("t4_async_reset", {25'd0, wr_gnt, rd_gnt, oe, wr_beat, rd_beat, ta_busy, dir}, 32'd0);
        model_reset();
        wr_req = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        clr_obs();
        repeat (4) tick();
        check_eq("t4_no_regrant", n_wg_obs, 0);
        check_eq("t4_oe_after", n_oe_obs, 0);

        // 6: request withdrawn during turnaround, both directions
        clr_obs();
        drop_in_ta = 1'b1;
        wr_len = 8'd3; wr_req = 1'b1;
        drain("t6a_timeout", 10);
        tick();
        check_eq("t6a_gnts", n_wg_obs, 0);
        check_eq("t6a_ta_cycles", n_ta_obs, 1);
        check_eq("t6a_dir_kept", {31'd0, dir}, 32'd1);
        clr_obs();
        rd_len = 8'd3; rd_req = 1'b1;
        drain("t6b_timeout", 10);
        tick();
        check_eq("t6b_gnts", n_rg_obs, 0);
        check_eq("t6b_ta_cycles", n_ta_obs, 2);
        check_eq("t6b_dir_kept", {31'd0, dir}, 32'd0);
        drop_in_ta = 1'b0;

        // random traffic against the model
        rnd_mode = 1'b1;
        repeat (3000) tick();
        rnd_mode = 1'b0;
        wr_req = 1'b0; rd_req = 1'b0;
        drain("rand_timeout", 400);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
